pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage RV32 pipeline. Drives enable/flush of the
//  IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC. Resolves load-use hazards,

---
 rtl/pipeline_hazard_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage RV32 pipeline.
// Handles load-use bubbles, taken-branch squashes and data-memory wait states.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_rs1/id_rs2            source registers of the ID instruction
//   id_uses_rs1/id_uses_rs2  ID instruction actually reads rs1/rs2
//   ex_load, ex_rd           EX holds a load writing ex_rd
//   ex_branch_taken          EX resolved a taken branch/jump
//   mem_req, mem_ack         MEM access request / completion
//   dmem_valid               request strobe to data memory
//   pc_en, *_en              stage register load enables
//   if_id_flush, id_ex_flush stage register clear-to-NOP
//   mem_wb_bubble            MEM/WB loads with write controls cleared
//   stall_cycles             saturating count of cycles with pc_en=0
//   mem_timeout_err          sticky memory-timeout error
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_load,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             dmem_valid,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_bubble,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             mem_timeout_err
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM_WAIT,
        ST_ERROR
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;

    logic st_run;
    logic st_wait;
    logic st_err;
    logic rs1_hit;
    logic rs2_hit;
    logic load_use;
    logic mem_stall;
    logic sel_mem;
    logic sel_br;
    logic sel_lu;

    assign st_run  = (state == ST_RUN);
    assign st_wait = (state == ST_MEM_WAIT);
    assign st_err  = (state == ST_ERROR);

    assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);

    // x0 is never a real dependency.
    assign load_use = ex_load && (ex_rd != 5'd0)
                   && (rs1_hit || rs2_hit);

    assign mem_stall = (st_run && mem_req && !mem_ack)
                    || (st_wait && !mem_ack)
                    || st_err;

    // Priority is resolved here so the selects are one-hot.
    assign sel_mem = !rst && mem_stall;
    assign sel_br  = !rst && !mem_stall && ex_branch_taken;
    assign sel_lu  = !rst && !mem_stall && !ex_branch_taken
                  && load_use;

    assign dmem_valid = !rst
                     && ((st_run && mem_req) || st_wait);

    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_en     = 1'b1;
        mem_wb_bubble = 1'b0;
        unique case (1'b1)
            sel_mem: begin
                // Freeze the front end; MEM/WB drains a bubble.
                pc_en         = 1'b0;
                if_id_en      = 1'b0;
                id_ex_en      = 1'b0;
                ex_mem_en     = 1'b0;
                mem_wb_bubble = 1'b1;
            end
            sel_br: begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end
            sel_lu: begin
                // Hold IF/ID, inject one bubble into EX.
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_RUN;
            wait_cnt        <= '0;
            stall_cycles    <= '0;
            mem_timeout_err <= 1'b0;
        end else begin
            if (!pc_en && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);

            case (state)
                ST_RUN: begin
                    if (mem_req && !mem_ack) begin
                        state    <= ST_MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                ST_MEM_WAIT: begin
                    // Ack beats a timeout landing on the same cycle.
                    if (mem_ack) begin
                        state <= ST_RUN;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state           <= ST_ERROR;
                        mem_timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ST_ERROR: begin
                    state <= ST_ERROR;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vectors and sequences
// for the pipeline stall/flush sequencer.
module tb_pipeline_hazard_ctrl;

    localparam int CW = 5;
    localparam logic [CW-1:0] SAT = '1;

    // {dmem_valid,pc_en,if_id_en,if_id_flush,
    //  id_ex_en,id_ex_flush,ex_mem_en,mem_wb_bubble}
    localparam logic [7:0] O_NORM  = 8'b0110_1010;
    localparam logic [7:0] O_NORMV = 8'b1110_1010;
    localparam logic [7:0] O_LU    = 8'b0000_1110;
    localparam logic [7:0] O_LUV   = 8'b1000_1110;
    localparam logic [7:0] O_BR    = 8'b0111_1110;
    localparam logic [7:0] O_BRV   = 8'b1111_1110;
    localparam logic [7:0] O_FRZV  = 8'b1000_0001;
    localparam logic [7:0] O_ERR   = 8'b0000_0001;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_uses_rs1, id_uses_rs2;
    logic          ex_load, ex_branch_taken;
    logic          mem_req, mem_ack;
    logic          dmem_valid, pc_en, if_id_en, if_id_flush;
    logic          id_ex_en, id_ex_flush, ex_mem_en;
    logic          mem_wb_bubble, mem_timeout_err;
    logic [CW-1:0] stall_cycles;
    logic [7:0]    outs;

    always #5 clk = ~clk;

    assign outs = {dmem_valid, pc_en, if_id_en, if_id_flush,
                   id_ex_en, id_ex_flush, ex_mem_en,
                   mem_wb_bubble};

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT(16),
        .CNT_W      (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_uses_rs1    (id_uses_rs1),
        .id_uses_rs2    (id_uses_rs2),
        .ex_load        (ex_load),
        .ex_rd          (ex_rd),
        .ex_branch_taken(ex_branch_taken),
        .mem_req        (mem_req),
        .mem_ack        (mem_ack),
        .dmem_valid     (dmem_valid),
        .pc_en          (pc_en),
        .if_id_en       (if_id_en),
        .if_id_flush    (if_id_flush),
        .id_ex_en       (id_ex_en),
        .id_ex_flush    (id_ex_flush),
        .ex_mem_en      (ex_mem_en),
        .mem_wb_bubble  (mem_wb_bubble),
        .stall_cycles   (stall_cycles),
        .mem_timeout_err(mem_timeout_err)
    );

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       ld;
        logic [4:0] rd;
        logic       br;
        logic       req;
        logic       ack;
        logic [7:0] exp;
    } vec_t;

    vec_t          tv[13];
    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] exp_sc = '0;

    task automatic chk(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, act, exp);
        end
    endtask

    task automatic set_in(input vec_t v);
        id_rs1          = v.rs1;
        id_rs2          = v.rs2;
        id_uses_rs1     = v.u1;
        id_uses_rs2     = v.u2;
        ex_load         = v.ld;
        ex_rd           = v.rd;
        ex_branch_taken = v.br;
        mem_req         = v.req;
        mem_ack         = v.ack;
    endtask

    task automatic idle();
        vec_t v;
        v = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,
              1'b0, 1'b0, 1'b0, 8'd0};
        set_in(v);
    endtask

    // Check combinational outputs, clock once, check
    // the counter against the bench model and the error flag.
    task automatic cyc(input logic [7:0] exp,
                       input logic exp_err,
                       input string tag);
        #1;
        chk({tag, ".outs"}, 32'(outs), 32'(exp));
        @(posedge clk);
        if (rst)
            exp_sc = '0;
        else if (!exp[6] && exp_sc != SAT)
            exp_sc = exp_sc + 1'b1;
        #1;
        chk({tag, ".stall"}, 32'(stall_cycles), 32'(exp_sc));
        chk({tag, ".err"}, 32'(mem_timeout_err),
            32'(exp_err));
    endtask

    initial begin
        tv[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,
                   1'b0, 1'b0, 1'b0, O_NORM};
        tv[1]  = '{5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 5'd5,
                   1'b0, 1'b0, 1'b0, O_LU};
        tv[2]  = '{5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5,
                   1'b0, 1'b0, 1'b0, O_LU};
        tv[3]  = '{5'd5, 5'd1, 1'b0, 1'b1, 1'b1, 5'd5,
                   1'b0, 1'b0, 1'b0, O_NORM};
        tv[4]  = '{5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0,
                   1'b0, 1'b0, 1'b0, O_NORM};
        tv[5]  = '{5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 5'd5,
                   1'b1, 1'b0, 1'b0, O_BR};
        tv[6]  = '{5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 5'd9,
                   1'b1, 1'b0, 1'b0, O_BR};
        tv[7]  = '{5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 5'd5,
                   1'b0, 1'b0, 1'b0, O_NORM};
        tv[8]  = '{5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3,
                   1'b0, 1'b1, 1'b1, O_NORMV};
        tv[9]  = '{5'd7, 5'd2, 1'b1, 1'b0, 1'b1, 5'd7,
                   1'b0, 1'b1, 1'b1, O_LUV};
        tv[10] = '{5'd7, 5'd2, 1'b1, 1'b0, 1'b1, 5'd7,
                   1'b1, 1'b1, 1'b1, O_BRV};
        tv[11] = '{5'd31, 5'd0, 1'b1, 1'b0, 1'b1, 5'd31,
                   1'b0, 1'b0, 1'b0, O_LU};
        tv[12] = '{5'd4, 5'd6, 1'b1, 1'b1, 1'b1, 5'd5,
                   1'b0, 1'b0, 1'b0, O_NORM};

        // Reset forces outputs even with hazards present.
        rst = 1'b1;
        set_in(tv[10]);
        mem_ack = 1'b0;
        cyc(O_NORM, 1'b0, "rst0");
        cyc(O_NORM, 1'b0, "rst1");
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            set_in(tv[i]);
            cyc(tv[i].exp, 1'b0, $sformatf("vec%0d", i));
        end

        // Memory ack three cycles after request.
        idle();
        mem_req = 1'b1;
        cyc(O_FRZV, 1'b0, "ack3_run");
        cyc(O_FRZV, 1'b0, "ack3_w0");
        cyc(O_FRZV, 1'b0, "ack3_w1");
        mem_ack = 1'b1;
        cyc(O_NORMV, 1'b0, "ack3_ack");
        idle();
        cyc(O_NORM, 1'b0, "ack3_after");

        // Branch held through a memory wait.
        idle();
        mem_req = 1'b1;
        ex_branch_taken = 1'b1;
        cyc(O_FRZV, 1'b0, "brw_run");
        cyc(O_FRZV, 1'b0, "brw_w0");
        mem_ack = 1'b1;
        cyc(O_BRV, 1'b0, "brw_ack");
        idle();
        cyc(O_NORM, 1'b0, "brw_after");

        // Timeout: 1 RUN + 16 MEM_WAIT frozen cycles.
        idle();
        mem_req = 1'b1;
        cyc(O_FRZV, 1'b0, "to_run");
        for (int i = 0; i < 15; i++)
            cyc(O_FRZV, 1'b0, $sformatf("to_w%0d", i));
        cyc(O_FRZV, 1'b1, "to_w15");
        for (int i = 0; i < 8; i++) begin
            mem_ack = i[0];
            cyc(O_ERR, 1'b1, $sformatf("err%0d", i));
        end
        chk("stall_sat", 32'(stall_cycles), 32'(SAT));

        rst = 1'b1;
        cyc(O_NORM, 1'b0, "rst_err");
        rst = 1'b0;

        // Reset in the middle of a memory wait.
        idle();
        mem_req = 1'b1;
        cyc(O_FRZV, 1'b0, "rw_run");
        cyc(O_FRZV, 1'b0, "rw_w0");
        rst = 1'b1;
        cyc(O_NORM, 1'b0, "rw_rst");
        rst = 1'b0;
        idle();
        cyc(O_NORM, 1'b0, "rw_after");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
